// File: rtl/audio_buffer_player_pkg.sv
// Shared buffer constants for the audio buffer player and its I2S back end.
package audio_buffer_player_pkg;
  localparam int BUFFER_ADDR_BITS = 9;
  localparam int BYTES_PER_FRAME  = 4;
  localparam int SAMPLE_W         = 16;
  localparam int FRAME_W          = 2 * SAMPLE_W;

  // Bit offset of each buffer byte inside the {L,R} frame (L_lo, L_hi, R_lo, R_hi).
  function automatic logic [4:0] lane_lsb(input logic [1:0] b);
    case (b)
      2'd0:    lane_lsb = 5'd16;
      2'd1:    lane_lsb = 5'd24;
      2'd2:    lane_lsb = 5'd0;
      default: lane_lsb = 5'd8;
    endcase
  endfunction
endpackage

// File: rtl/audio_buffer_player_i2s_serializer.sv
// Free-running BCLK divider, 32-bit frame shifter and I2S word select.
module i2s_serializer
  import audio_buffer_player_pkg::*;
#(
  parameter int HALF = 71
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FRAME_W-1:0] i_frame,
  output logic               o_load,
  output logic               o_bclk,
  output logic               o_lrclk,
  output logic               o_data
);
  localparam int DW = (HALF > 1) ? $clog2(HALF) : 1;

  logic [DW-1:0]      r_div;
  logic               r_bclk, r_lr, r_data;
  logic [4:0]         r_bit;
  logic [FRAME_W-1:0] r_sh;
  logic               w_tog, w_fall;
  logic [4:0]         w_next_bit;

  assign w_tog      = (r_div == DW'(HALF - 1));
  assign w_fall     = w_tog & r_bclk;
  assign w_next_bit = r_bit + 5'd1;
  assign o_load     = w_fall && (r_bit == 5'd31);
  assign o_bclk     = r_bclk;
  assign o_lrclk    = r_lr;
  assign o_data     = r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div  <= '0;
      r_bclk <= 1'b0;
      r_bit  <= '0;
      r_lr   <= 1'b0;
      r_data <= 1'b0;
      r_sh   <= '0;
    end else begin
      r_div <= w_tog ? '0 : r_div + DW'(1);
      if (w_tog) r_bclk <= ~r_bclk;
      if (w_fall) begin
        r_bit <= w_next_bit;
        // Word select runs one bit ahead of the data word it names.
        r_lr  <= (w_next_bit >= 5'd15) && (w_next_bit <= 5'd30);
        if (o_load) begin
          r_data <= i_frame[FRAME_W-1];
          r_sh   <= {i_frame[FRAME_W-2:0], 1'b0};
        end else begin
          r_data <= r_sh[FRAME_W-1];
          r_sh   <= {r_sh[FRAME_W-2:0], 1'b0};
        end
      end
    end
  end
endmodule

// File: rtl/audio_buffer_player.sv
// Ping-pong buffer reader: fetches one stereo frame ahead and feeds the I2S serializer.
module audio_buffer_player
  import audio_buffer_player_pkg::*;
#(
  parameter int BCLK_HALF_PERIOD = 71,
  parameter int RAM_RD_LATENCY   = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable_i,
  input  logic                        audio_buffer_filled_i,
  output logic                        audio_buffer_empty_o,
  output logic                        buffer_active_sel_o,
  output logic [BUFFER_ADDR_BITS-1:0] buffer_rd_addr_o,
  input  logic [7:0]                  ram_rd_data_i,
  output logic                        i2s_bclk_o,
  output logic                        i2s_lrclk_o,
  output logic                        i2s_data_o,
  output logic                        underrun_o
);
  localparam int LAT = RAM_RD_LATENCY;

  typedef enum logic [1:0] {WAIT_SWAP, FETCH, HOLD} state_t;

  state_t                      r_state, w_state_n;
  logic                        r_empty, r_sel, r_issued, r_staged, r_underrun;
  logic [BUFFER_ADDR_BITS-1:0] r_addr;
  logic [FRAME_W-1:0]          r_stage;
  logic [LAT:1]                r_vld_pipe;
  logic [LAT:1][1:0]           r_tag_pipe;
  logic                        w_issue, w_swap, w_load, w_fetch_done;
  logic [FRAME_W-1:0]          w_frame;

  assign w_fetch_done = r_vld_pipe[LAT] && (r_tag_pipe[LAT] == 2'd3);
  assign w_frame      = (enable_i && r_staged) ? r_stage : '0;

  always_comb begin
    w_state_n = r_state;
    w_issue   = 1'b0;
    w_swap    = 1'b0;
    case (r_state)
      WAIT_SWAP: if (enable_i && audio_buffer_filled_i) begin
        w_swap    = 1'b1;
        w_state_n = FETCH;
      end
      FETCH: begin
        w_issue = enable_i && !r_issued;
        if (w_fetch_done) w_state_n = HOLD;
      end
      HOLD: if (w_load && enable_i)
        w_state_n = (r_addr == '0) ? WAIT_SWAP : FETCH;
      default: w_state_n = WAIT_SWAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= WAIT_SWAP;
      r_empty    <= 1'b1;
      r_sel      <= 1'b0;
      r_addr     <= '0;
      r_issued   <= 1'b0;
      r_staged   <= 1'b0;
      r_underrun <= 1'b0;
      r_stage    <= '0;
      r_vld_pipe <= '0;
      r_tag_pipe <= '0;
    end else begin
      r_state <= w_state_n;
      r_empty <= (w_state_n == WAIT_SWAP);
      if (w_swap) begin
        r_sel  <= ~r_sel;
        r_addr <= '0;
      end else if (w_issue) begin
        r_addr <= r_addr + BUFFER_ADDR_BITS'(1);
      end
      if (w_issue && r_addr[1:0] == 2'd3) r_issued <= 1'b1;
      else if (w_fetch_done)              r_issued <= 1'b0;
      // In-flight reads always drain so a pause never strands a half-built frame.
      for (int i = LAT; i > 1; i--) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_tag_pipe[i] <= r_tag_pipe[i-1];
      end
      r_vld_pipe[1] <= w_issue;
      r_tag_pipe[1] <= r_addr[1:0];
      if (r_vld_pipe[LAT]) r_stage[lane_lsb(r_tag_pipe[LAT]) +: 8] <= ram_rd_data_i;
      if (w_fetch_done)              r_staged <= 1'b1;
      else if (w_load && enable_i)   r_staged <= 1'b0;
      if (w_load && enable_i && !r_staged) r_underrun <= 1'b1;
    end
  end

  i2s_serializer #(.HALF(BCLK_HALF_PERIOD)) u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_frame (w_frame),
    .o_load  (w_load),
    .o_bclk  (i2s_bclk_o),
    .o_lrclk (i2s_lrclk_o),
    .o_data  (i2s_data_o)
  );

  assign audio_buffer_empty_o = r_empty;
  assign buffer_active_sel_o  = r_sel;
  assign buffer_rd_addr_o     = r_addr;
  assign underrun_o           = r_underrun;
endmodule

// File: tb/tb_audio_buffer_player.sv
// Directed bench: two-stage RAM model, I2S frame decoder, scenario tasks.
module tb_audio_buffer_player;
  localparam int HALF = 4;
  localparam int LAT  = 2;
  localparam int AW   = 9;

  logic          clk = 1'b0, rst_n = 1'b0, enable = 1'b0, filled = 1'b0;
  logic          empty, sel, bclk, lrclk, sdata, underrun;
  logic [AW-1:0] addr;
  logic [7:0]    ram_d1, ram_q;
  logic [7:0]    mem [0:1][0:511];

  int total = 0;
  int bad   = 0;
  int b0    = 0;

  audio_buffer_player #(.BCLK_HALF_PERIOD(HALF), .RAM_RD_LATENCY(LAT)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .enable_i              (enable),
    .audio_buffer_filled_i (filled),
    .audio_buffer_empty_o  (empty),
    .buffer_active_sel_o   (sel),
    .buffer_rd_addr_o      (addr),
    .ram_rd_data_i         (ram_q),
    .i2s_bclk_o            (bclk),
    .i2s_lrclk_o           (lrclk),
    .i2s_data_o            (sdata),
    .underrun_o            (underrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_d1 <= mem[sel][addr];
    ram_q  <= ram_d1;
  end

  // I2S receiver: frame ends on the bit where LRCLK falls (bit 31 of the frame).
  logic [31:0] frames [0:1023];
  int          nfr = 0;
  int          lr_bad = 0;
  logic [31:0] m_sh = '0;
  logic        m_prev = 1'b0, m_sync = 1'b0;
  logic [4:0]  m_bit = '0;

  always @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      m_prev = 1'b0;
      m_sync = 1'b0;
    end else begin
      if (m_prev && !lrclk) begin
        if (m_sync && nfr < 1024) begin
          frames[nfr] = {m_sh[30:0], sdata};
          nfr++;
        end
        m_sync = 1'b1;
        m_bit  = 5'd31;
      end else begin
        m_bit = m_bit + 5'd1;
      end
      if (m_sync && !m_prev && lrclk && m_bit != 5'd15) lr_bad++;
      m_sh   = {m_sh[30:0], sdata};
      m_prev = lrclk;
    end
  end

  function automatic logic [31:0] exp_frame(input int h, input int i);
    logic [15:0] l, r;
    if (h == 1 && i == 0) return 32'h8001_1234;
    l = (h == 1) ? 16'(32'h1000 + i) : 16'(32'h2000 + i);
    r = (h == 1) ? 16'(32'hA000 + i) : 16'(32'hB000 + i);
    return {l, r};
  endfunction

  initial begin
    logic [31:0] f;
    for (int h = 0; h < 2; h++)
      for (int i = 0; i < 128; i++) begin
        f = exp_frame(h, i);
        mem[h][4*i]   = f[23:16];
        mem[h][4*i+1] = f[31:24];
        mem[h][4*i+2] = f[7:0];
        mem[h][4*i+3] = f[15:8];
      end
  end

  function automatic logic [14:0] outs();
    return {empty, sel, addr, bclk, lrclk, sdata, underrun};
  endfunction

  task automatic wait_frames(input int target, input int bound, input string nm);
    int c = 0;
    while (nfr < target && c < bound) begin
      @(negedge clk);
      c++;
    end
    total++;
    if (nfr < target) begin
      bad++;
      $display("FAIL %s timeout: frames=%0d need=%0d", nm, nfr, target);
    end
  endtask

  task automatic test_reset();
    int n = 0;
    rst_n = 1'b0; enable = 1'b0; filled = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (outs() !== 15'h4000) begin
      bad++;
      $display("FAIL reset_outs: got %h want %h", outs(), 15'h4000);
    end
    rst_n = 1'b1;
    while (bclk !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (n !== HALF) begin
      bad++;
      $display("FAIL first_bclk_rise: got %0d cycles want %0d", n, HALF);
    end
  endtask

  task automatic test_underrun();
    logic e_bad = 1'b0, d_bad = 1'b0, u250 = 1'b1;
    @(negedge clk); rst_n = 1'b0; enable = 1'b1; filled = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk); #1;
      if (empty !== 1'b1) e_bad = 1'b1;
      if (sdata !== 1'b0) d_bad = 1'b1;
      if (c == 250) u250 = underrun;
    end
    total++;
    if (e_bad !== 1'b0) begin bad++; $display("FAIL underrun_empty: got dropped want held 1"); end
    total++;
    if (d_bad !== 1'b0) begin bad++; $display("FAIL underrun_data: got 1 want 0"); end
    total++;
    if (u250 !== 1'b0) begin bad++; $display("FAIL underrun_early: got %b want 0", u250); end
    total++;
    if (underrun !== 1'b1) begin bad++; $display("FAIL underrun_set: got %b want 1", underrun); end
  endtask

  task automatic test_play_full();
    int          c = 0, ecyc = 0;
    logic [AW-1:0] a_e = '1;
    logic [31:0] ex;
    @(negedge clk); rst_n = 1'b0; enable = 1'b1; filled = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (sel !== 1'b0) begin bad++; $display("FAIL pre_swap_sel: got %b want 0", sel); end
    filled = 1'b1;
    b0 = nfr;
    @(posedge clk); #1;
    total++;
    if ({sel, empty} !== 2'b10) begin
      bad++; $display("FAIL swap_sel_empty: got %b want 10", {sel, empty});
    end
    while (nfr < b0 + 130 && c < 40000) begin
      @(negedge clk); c++;
      if (empty === 1'b1) begin
        if (ecyc == 0) a_e = addr;
        ecyc++;
      end
    end
    total++;
    if (nfr < b0 + 130) begin bad++; $display("FAIL play_timeout: frames=%0d", nfr - b0); end
    for (int i = 0; i < 130; i++) begin
      ex = (i < 128) ? exp_frame(1, i) : exp_frame(0, i - 128);
      total++;
      if (frames[b0+i] !== ex) begin
        bad++; $display("FAIL frame_%0d: got %h want %h", i, frames[b0+i], ex);
      end
    end
    total++;
    if (ecyc !== 1) begin bad++; $display("FAIL wrap_empty_cycles: got %0d want 1", ecyc); end
    total++;
    if (a_e !== '0) begin bad++; $display("FAIL wrap_addr: got %0d want 0", a_e); end
    total++;
    if (sel !== 1'b0) begin bad++; $display("FAIL second_swap_sel: got %b want 0", sel); end
    total++;
    if (underrun !== 1'b0) begin bad++; $display("FAIL play_underrun: got %b want 0", underrun); end
    total++;
    if (lr_bad !== 0) begin bad++; $display("FAIL lrclk_lead: got %0d bad edges want 0", lr_bad); end
  endtask

  task automatic test_pause();
    int            base, j;
    logic [AW-1:0] a0;
    logic          moved = 1'b0;
    wait_frames(nfr + 1, 400, "pause_align");
    enable = 1'b0;
    base = nfr;
    a0 = addr;
    while (nfr < base + 10) begin
      @(negedge clk);
      if (addr !== a0) moved = 1'b1;
      if (nfr >= 1024) break;
    end
    enable = 1'b1;
    wait_frames(base + 11, 400, "pause_resume");
    for (int i = 0; i < 10; i++) begin
      total++;
      if (frames[base+i] !== 32'h0) begin
        bad++; $display("FAIL pause_zero_%0d: got %h want 0", i, frames[base+i]);
      end
    end
    j = base - 1 - b0 - 128;
    total++;
    if (frames[base+10] !== exp_frame(0, j + 1)) begin
      bad++; $display("FAIL resume_frame: got %h want %h", frames[base+10], exp_frame(0, j + 1));
    end
    total++;
    if (moved !== 1'b0) begin bad++; $display("FAIL pause_addr: moved from %0d", a0); end
    total++;
    if (underrun !== 1'b0) begin bad++; $display("FAIL pause_underrun: got %b want 0", underrun); end
  endtask

  task automatic test_reset_midfetch();
    int c = 0;
    int b;
    while (addr[1:0] !== 2'd2 && c < 600) begin
      @(negedge clk); c++;
    end
    total++;
    if (addr[1:0] !== 2'd2) begin bad++; $display("FAIL midfetch_find: addr %0d", addr); end
    rst_n = 1'b0;
    #1;
    total++;
    if (outs() !== 15'h4000) begin
      bad++; $display("FAIL midfetch_reset_outs: got %h want %h", outs(), 15'h4000);
    end
    @(negedge clk); rst_n = 1'b1;
    b = nfr;
    @(posedge clk); #1;
    total++;
    if ({sel, addr} !== {1'b1, 9'd0}) begin
      bad++; $display("FAIL replay_swap: got sel=%b addr=%0d want sel=1 addr=0", sel, addr);
    end
    wait_frames(b + 2, 1000, "replay");
    total++;
    if (frames[b] !== exp_frame(1, 0)) begin
      bad++; $display("FAIL replay_frame0: got %h want %h", frames[b], exp_frame(1, 0));
    end
    total++;
    if (frames[b+1] !== exp_frame(1, 1)) begin
      bad++; $display("FAIL replay_frame1: got %h want %h", frames[b+1], exp_frame(1, 1));
    end
    total++;
    if (underrun !== 1'b0) begin bad++; $display("FAIL replay_underrun: got %b want 0", underrun); end
  endtask

  initial begin
    test_reset();
    test_underrun();
    test_play_full();
    test_pause();
    test_reset_midfetch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
